// File: rtl/jtag_shift_engine_pkg.sv
// jtag_shift_engine_pkg
// Shared types and constants for the JTAG shift engine.
//   jtag_eng_state_e : engine FSM states
//   TLR_TMS_ONES     : TMS=1 clocks that force any TAP into Test-Logic-Reset
//   TRST_PERIODS     : TCK periods TRST is held low (JTAG_SHIFT_ENGINE_TRST_EN builds)
//   DR/IR_WALK_IN_*  : TMS patterns (bit 0 first) that walk RTI -> Shift-DR/IR
//   walk_in_tms()    : picks one walk-in TMS bit
package jtag_shift_engine_pkg;

    typedef enum logic [2:0] {
        TLR_SEQ,
        IDLE,
        WALK_IN,
        SHIFT,
        WALK_OUT,
        RESP
    } jtag_eng_state_e;

    localparam int TLR_TMS_ONES = 5;
    localparam int TRST_PERIODS = 2;

    // RTI -> Select-DR -> Capture-DR -> Shift-DR
    localparam logic [3:0] DR_WALK_IN_TMS = 4'b0001;
    localparam int         DR_WALK_IN_LEN = 3;

    // RTI -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
    localparam logic [3:0] IR_WALK_IN_TMS = 4'b0011;
    localparam int         IR_WALK_IN_LEN = 4;

    // Returns the TMS value for walk-in TCK period idx.
    function automatic logic walk_in_tms(input logic is_ir, input logic [1:0] idx);
        logic [3:0] pat;
        pat = is_ir ? IR_WALK_IN_TMS : DR_WALK_IN_TMS;
        return pat[idx];
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen
// Divides the reference clock down to TCK. While en is high a phase counter
// runs 0..DIV-1 and tck toggles each time it wraps; with en low the counter
// is cleared and tck rests low.
// Ports:
//   clk  : reference clock
//   rst  : synchronous active-high reset
//   en   : run TCK
//   tck  : registered TCK
//   rise : high in the ref cycle whose edge takes tck 0->1
//   fall : high in the ref cycle whose edge takes tck 1->0
module jtag_tck_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int PH_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PH_W-1:0] phase;
    logic            wrap;

    // The strobes announce the edge the next clock will produce, so the
    // engine can move TMS/TDI and sample TDO in lock-step with tck.
    always_comb begin
        wrap = en && (phase == PH_W'(DIV - 1));
        rise = wrap && !tck;
        fall = wrap && tck;
    end

    // Phase counter and TCK register; disabling parks tck low and restarts
    // the phase so the first rise always comes a full half-period later.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            tck   <= 1'b0;
        end else if (!en) begin
            phase <= '0;
            tck   <= 1'b0;
        end else if (wrap) begin
            phase <= '0;
            tck   <= ~tck;
        end else begin
            phase <= phase + PH_W'(1);
        end
    end

endmodule

// File: rtl/jtag_shift_engine.sv
// jtag_shift_engine
// Turns IR/DR shift commands into complete TAP walks starting and ending in
// Run-Test/Idle, and returns the TDO bits captured during the shift.
// Optional feature macro: JTAG_SHIFT_ENGINE_TRST_EN drives jtag_trst_o low
// for the first TRST_PERIODS TCK periods of the reset sequence; without it
// jtag_trst_o is tied high.
// Ports:
//   ref_clk_i, rst_i        : clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o : command handshake
//   cmd_is_ir_i             : 1 = IR shift, 0 = DR shift
//   cmd_len_i               : bits to shift (1..MAX_LEN, else error)
//   cmd_data_i              : TDI bits, bit 0 first
//   rsp_valid_o/rsp_ready_i : response handshake
//   rsp_data_o              : captured TDO, bit 0 first, unused bits 0
//   rsp_err_o               : length error
//   jtag_tck_o/tms_o/tdi_o  : JTAG drive
//   jtag_trst_o             : JTAG reset, active-low
//   jtag_tdo_i              : JTAG data in
module jtag_shift_engine
    import jtag_shift_engine_pkg::*;
#(
    parameter int DIV     = 2,
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               ref_clk_i,
    input  logic               rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_is_ir_i,
    input  logic [LEN_W-1:0]   cmd_len_i,
    input  logic [MAX_LEN-1:0] cmd_data_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [MAX_LEN-1:0] rsp_data_o,
    output logic               rsp_err_o,
    output logic               jtag_tck_o,
    output logic               jtag_tms_o,
    output logic               jtag_tdi_o,
    output logic               jtag_trst_o,
    input  logic               jtag_tdo_i
);

    localparam int IDX_W = $clog2(MAX_LEN);

    jtag_eng_state_e    state;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   len_q;
    logic               is_ir_q;
    logic [MAX_LEN-1:0] data_q;
    logic               cmd_ready;
    logic               rsp_valid;
    logic               rsp_err;
    logic [MAX_LEN-1:0] rsp_data;
    logic               tms;
    logic               tdi;
    logic               tck_en;
    logic               tck;
    logic               rise;
    logic               fall;
    logic               walk_in_last;
    logic               len_bad;

    // TCK only runs while a TAP walk is in progress.
    always_comb begin
        tck_en = (state == TLR_SEQ) || (state == WALK_IN) ||
                 (state == SHIFT) || (state == WALK_OUT);
        walk_in_last = is_ir_q ? (cnt == LEN_W'(IR_WALK_IN_LEN - 1))
                               : (cnt == LEN_W'(DR_WALK_IN_LEN - 1));
        len_bad = (cmd_len_i == '0) || (cmd_len_i > LEN_W'(MAX_LEN));
    end

    jtag_tck_gen #(
        .DIV (DIV)
    ) u_tck_gen (
        .clk  (ref_clk_i),
        .rst  (rst_i),
        .en   (tck_en),
        .tck  (tck),
        .rise (rise),
        .fall (fall)
    );

    // Engine FSM. cnt is the TCK period index inside the current state. On
    // each falling edge the period just finished is retired and TMS/TDI for
    // the next period are presented, so every bit has a full low half-period
    // of setup before the rise that the TAP samples it on. Falling edges at
    // the end of a state hand over to the next state with its first bit
    // already driven.
    always_ff @(posedge ref_clk_i) begin
        if (rst_i) begin
            state     <= TLR_SEQ;
            cnt       <= '0;
            len_q     <= '0;
            is_ir_q   <= 1'b0;
            data_q    <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
        end else begin
            case (state)
                TLR_SEQ: begin
                    if (fall) begin
                        if (cnt == LEN_W'(TLR_TMS_ONES)) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            tms       <= 1'b0;
                            cmd_ready <= 1'b1;
                        end else begin
                            cnt <= cnt + LEN_W'(1);
                            tms <= (cnt < LEN_W'(TLR_TMS_ONES - 1));
                        end
                    end
                end

                IDLE: begin
                    if (cmd_valid_i && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        rsp_data  <= '0;
                        cnt       <= '0;
                        if (len_bad) begin
                            state   <= RESP;
                            rsp_err <= 1'b1;
                        end else begin
                            state   <= WALK_IN;
                            rsp_err <= 1'b0;
                            is_ir_q <= cmd_is_ir_i;
                            len_q   <= cmd_len_i;
                            data_q  <= cmd_data_i;
                            tms     <= 1'b1;
                        end
                    end
                end

                WALK_IN: begin
                    if (fall) begin
                        if (walk_in_last) begin
                            state  <= SHIFT;
                            cnt    <= '0;
                            tms    <= (len_q == LEN_W'(1));
                            tdi    <= data_q[0];
                            data_q <= data_q >> 1;
                        end else begin
                            cnt <= cnt + LEN_W'(1);
                            tms <= walk_in_tms(is_ir_q, 2'(cnt + LEN_W'(1)));
                        end
                    end
                end

                SHIFT: begin
                    if (rise) begin
                        rsp_data[cnt[IDX_W-1:0]] <= jtag_tdo_i;
                    end
                    if (fall) begin
                        if (cnt == len_q - LEN_W'(1)) begin
                            state <= WALK_OUT;
                            cnt   <= '0;
                            tms   <= 1'b1;
                            tdi   <= 1'b0;
                        end else begin
                            cnt    <= cnt + LEN_W'(1);
                            tms    <= (cnt + LEN_W'(2) == len_q);
                            tdi    <= data_q[0];
                            data_q <= data_q >> 1;
                        end
                    end
                end

                WALK_OUT: begin
                    if (fall) begin
                        tms <= 1'b0;
                        if (cnt == LEN_W'(1)) begin
                            state <= RESP;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + LEN_W'(1);
                        end
                    end
                end

                RESP: begin
                    if (rsp_valid && rsp_ready_i) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else begin
                        rsp_valid <= 1'b1;
                    end
                end

                default: begin
                    state <= TLR_SEQ;
                    cnt   <= '0;
                    tms   <= 1'b1;
                end
            endcase
        end
    end

`ifdef JTAG_SHIFT_ENGINE_TRST_EN
    logic trst;

    // TRST is pulsed low across the opening TCK periods of every reset
    // sequence and released on the falling edge that ends the window.
    always_ff @(posedge ref_clk_i) begin
        if (rst_i) begin
            trst <= 1'b1;
        end else if ((state == TLR_SEQ) && (cnt < LEN_W'(TRST_PERIODS)) &&
                     !(fall && (cnt == LEN_W'(TRST_PERIODS - 1)))) begin
            trst <= 1'b0;
        end else begin
            trst <= 1'b1;
        end
    end

    assign jtag_trst_o = trst;
`else
    assign jtag_trst_o = 1'b1;
`endif

    assign cmd_ready_o = cmd_ready;
    assign rsp_valid_o = rsp_valid;
    assign rsp_data_o  = rsp_data;
    assign rsp_err_o   = rsp_err;
    assign jtag_tck_o  = tck;
    assign jtag_tms_o  = tms;
    assign jtag_tdi_o  = tdi;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// tb_jtag_shift_engine
// Directed bench for jtag_shift_engine (DIV=2, MAX_LEN=64). A negedge
// monitor counts TCK edges, logs TMS at each rise and models the TDO source
// (constant 0/1, or TDI looped back through one TCK of delay).
module tb_jtag_shift_engine;

    localparam int DIV     = 2;
    localparam int MAX_LEN = 64;
    localparam int LEN_W   = 7;

    typedef struct {
        logic        is_ir;
        int          len;
        logic [63:0] data;
        int          tdo_mode;
        logic [63:0] exp_data;
        logic        exp_err;
        int          exp_tck;
    } vec_t;

    logic               ref_clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               cmd_valid_i = 1'b0;
    logic               cmd_ready_o;
    logic               cmd_is_ir_i = 1'b0;
    logic [LEN_W-1:0]   cmd_len_i = '0;
    logic [MAX_LEN-1:0] cmd_data_i = '0;
    logic               rsp_valid_o;
    logic               rsp_ready_i = 1'b0;
    logic [MAX_LEN-1:0] rsp_data_o;
    logic               rsp_err_o;
    logic               jtag_tck_o;
    logic               jtag_tms_o;
    logic               jtag_tdi_o;
    logic               jtag_trst_o;
    logic               jtag_tdo_i;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           last_edge_cyc = 0;
    int           edges = 0;
    int           rises = 0;
    int           trst_low = 0;
    int           tdo_mode = 0;
    logic         tck_prev = 1'b0;
    logic         loop_reg = 1'b0;
    logic [127:0] tms_log = '0;
    vec_t         vecs[8];
    vec_t         v_hold;
    vec_t         v_abort;
    vec_t         v_after;

    jtag_shift_engine #(
        .DIV     (DIV),
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) dut (
        .ref_clk_i   (ref_clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_is_ir_i (cmd_is_ir_i),
        .cmd_len_i   (cmd_len_i),
        .cmd_data_i  (cmd_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .jtag_tck_o  (jtag_tck_o),
        .jtag_tms_o  (jtag_tms_o),
        .jtag_tdi_o  (jtag_tdi_o),
        .jtag_trst_o (jtag_trst_o),
        .jtag_tdo_i  (jtag_tdo_i)
    );

    always #5 ref_clk_i = ~ref_clk_i;

    assign jtag_tdo_i = (tdo_mode == 2) ? loop_reg : (tdo_mode == 1);

    // Monitor: observes the JTAG pins half a ref cycle after each active edge.
    always @(negedge ref_clk_i) begin
        cyc++;
        if (jtag_tck_o !== tck_prev) begin
            edges++;
            last_edge_cyc = cyc;
            if (jtag_tck_o === 1'b1) begin
                if (rises < 128) tms_log[rises] = jtag_tms_o;
                rises++;
                loop_reg = jtag_tdi_o;
            end
        end
        tck_prev = jtag_tck_o;
        if (jtag_trst_o === 1'b0) trst_low++;
    end

    // Watchdog so the run can never hang.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic waitSample();
        @(negedge ref_clk_i);
        #1;
    endtask

    task automatic clearMon();
        edges = 0;
        rises = 0;
        tms_log = '0;
        trst_low = 0;
        loop_reg = 1'b0;
    endtask

    // Expected TMS at each TCK rise for a complete command.
    function automatic logic [127:0] expTms(input logic is_ir, input int len);
        logic [127:0] t;
        int k;
        t = '0;
        t[0] = 1'b1;
        k = 1;
        if (is_ir) begin
            t[k] = 1'b1;
            k++;
        end
        k = k + 2;
        for (int i = 0; i < len; i++) begin
            t[k] = (i == len - 1);
            k++;
        end
        t[k] = 1'b1;
        return t;
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cmd_ready"}, cmd_ready_o, 0);
        checkOutput({tag, "_rsp_valid"}, rsp_valid_o, 0);
        checkOutput({tag, "_rsp_data"}, rsp_data_o, 0);
        checkOutput({tag, "_rsp_err"}, rsp_err_o, 0);
        checkOutput({tag, "_tck"}, jtag_tck_o, 0);
        checkOutput({tag, "_tms"}, jtag_tms_o, 1);
        checkOutput({tag, "_tdi"}, jtag_tdi_o, 0);
        checkOutput({tag, "_trst"}, jtag_trst_o, 1);
    endtask

    // Waits for the reset walk to end and checks its TCK/TMS shape.
    task automatic checkTlr(input string tag);
        int n;
        n = 0;
        while (cmd_ready_o !== 1'b1 && n < 300) begin
            waitSample();
            n++;
        end
        checkOutput({tag, "_ready_timeout"}, (n < 300), 1);
        checkOutput({tag, "_rises"}, rises, 6);
        checkOutput({tag, "_edges"}, edges, 12);
        checkOutput({tag, "_tms"}, tms_log, 128'h1f);
        checkOutput({tag, "_tck_low"}, jtag_tck_o, 0);
        checkOutput({tag, "_ready_at_fall"}, cyc - last_edge_cyc, 0);
`ifdef JTAG_SHIFT_ENGINE_TRST_EN
        checkOutput({tag, "_trst_pulsed"}, (trst_low > 0), 1);
`else
        checkOutput({tag, "_trst_high"}, trst_low, 0);
`endif
    endtask

    task automatic applyStimulus(input vec_t v);
        int n;
        n = 0;
        while (cmd_ready_o !== 1'b1 && n < 300) begin
            waitSample();
            n++;
        end
        checkOutput("cmd_ready_timeout", (n < 300), 1);
        clearMon();
        tdo_mode    = v.tdo_mode;
        cmd_is_ir_i = v.is_ir;
        cmd_len_i   = LEN_W'(v.len);
        cmd_data_i  = v.data;
        cmd_valid_i = 1'b1;
        waitSample();
        cmd_valid_i = 1'b0;
        cmd_is_ir_i = ~v.is_ir;
        cmd_len_i   = LEN_W'($urandom_range(0, 127));
        cmd_data_i  = {$urandom, $urandom};
    endtask

    task automatic checkResponse(input string tag, input vec_t v);
        int n;
        n = 0;
        while (rsp_valid_o !== 1'b1 && n < 2000) begin
            waitSample();
            n++;
        end
        checkOutput({tag, "_rsp_timeout"}, (n < 2000), 1);
        checkOutput({tag, "_rsp_data"}, rsp_data_o, v.exp_data);
        checkOutput({tag, "_rsp_err"}, rsp_err_o, v.exp_err);
        checkOutput({tag, "_rises"}, rises, v.exp_tck);
        checkOutput({tag, "_cmd_ready"}, cmd_ready_o, 0);
        if (v.exp_err) begin
            checkOutput({tag, "_no_edges"}, edges, 0);
        end else begin
            checkOutput({tag, "_tms"}, tms_log, expTms(v.is_ir, v.len));
            checkOutput({tag, "_rsp_latency"}, cyc - last_edge_cyc, 1);
            checkOutput({tag, "_tck_low"}, jtag_tck_o, 0);
        end
    endtask

    task automatic consumeResp(input string tag);
        rsp_ready_i = 1'b1;
        waitSample();
        rsp_ready_i = 1'b0;
        checkOutput({tag, "_rsp_dropped"}, rsp_valid_o, 0);
        checkOutput({tag, "_idle_ready"}, cmd_ready_o, 1);
    endtask

    task automatic runVector(input string tag, input vec_t v);
        applyStimulus(v);
        checkResponse(tag, v);
        consumeResp(tag);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32, 64'hDEADBEEF, 2, 64'hBD5B7DDE, 1'b0, 37};
        vecs[1] = '{1'b1, 5, 64'h01, 1, 64'h1F, 1'b0, 11};
        vecs[2] = '{1'b0, 0, 64'hFFFF, 1, 64'h0, 1'b1, 0};
        vecs[3] = '{1'b0, 65, 64'hFFFF, 1, 64'h0, 1'b1, 0};
        vecs[4] = '{1'b0, 8, 64'hA5, 0, 64'h0, 1'b0, 13};
        vecs[5] = '{1'b0, 64, 64'h0123456789ABCDEF, 2, 64'h02468ACF13579BDE, 1'b0, 69};
        vecs[6] = '{1'b1, 1, 64'h1, 1, 64'h1, 1'b0, 7};
        vecs[7] = '{1'b0, 3, 64'h5, 2, 64'h2, 1'b0, 8};
        v_hold  = '{1'b0, 8, 64'h96, 1, 64'hFF, 1'b0, 13};
        v_abort = '{1'b0, 32, 64'hFFFFFFFF, 0, 64'h0, 1'b0, 37};
        v_after = '{1'b0, 8, 64'h3C, 2, 64'h78, 1'b0, 13};

        $display("[TB] reset and TLR sequence");
        waitSample();
        waitSample();
        checkResetValues("reset");
        clearMon();
        rst_i = 1'b0;
        checkTlr("tlr");

        $display("[TB] command vector table");
        for (int i = 0; i < 8; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i]);
        end

        $display("[TB] response back-pressure");
        applyStimulus(v_hold);
        checkResponse("hold", v_hold);
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            cmd_valid_i = 1'b1;
            cmd_len_i   = LEN_W'(8);
            cmd_data_i  = {$urandom, $urandom};
            waitSample();
            checkOutput($sformatf("hold_valid_%0d", i), rsp_valid_o, 1);
            checkOutput($sformatf("hold_data_%0d", i), rsp_data_o, 64'hFF);
            checkOutput($sformatf("hold_ready_%0d", i), cmd_ready_o, 0);
        end
        cmd_valid_i = 1'b0;
        checkOutput("hold_no_tck", edges, 0);
        consumeResp("hold");

        $display("[TB] reset during shift");
        applyStimulus(v_abort);
        begin
            int n;
            n = 0;
            while (rises < 14 && n < 500) begin
                waitSample();
                n++;
            end
            checkOutput("abort_reach_bit10", (n < 500), 1);
        end
        checkOutput("abort_tck_high", jtag_tck_o, 1);
        rst_i = 1'b1;
        waitSample();
        checkResetValues("abort");
        clearMon();
        rst_i = 1'b0;
        checkTlr("tlr2");
        runVector("after_abort", v_after);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_shift_engine.md
Name: jtag_shift_engine

Overview:
- Upstream stimulus stage for the MCU JTAG port. Drives jtag_tck, jtag_tms, jtag_tdi and jtag_trst of the core_v_mcu debug interface, and captures jtag_tdo.
- Turns IR/DR shift commands (valid/ready) into TAP state walks from Run-Test/Idle (RTI) and back.
- Returns the captured TDO bits as a response beat.
- Used by testbenches and by on-chip boot/debug bridges.

Parameters:
- DIV, 2: TCK half-period in ref_clk_i cycles (>=1). One TCK period = 2*DIV ref cycles.
- MAX_LEN, 64: maximum shift length; width of cmd_data_i and rsp_data_o.
- LEN_W, $clog2(MAX_LEN+1): width of cmd_len_i.

Ports:
- ref_clk_i  in  1  sole clock.
- rst_i  in  1  synchronous reset, active-high.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&&ready.
- cmd_is_ir_i  in  1  1 = IR shift, 0 = DR shift.
- cmd_len_i  in  LEN_W  bits to shift.
- cmd_data_i  in  MAX_LEN  TDI bits, bit 0 shifted first.
- rsp_valid_o  out  1  response valid, held until rsp_ready_i.
- rsp_ready_i  in  1  response consumed.
- rsp_data_o  out  MAX_LEN  captured TDO, bit 0 = first captured, bits >= len are 0.
- rsp_err_o  out  1  length error flag.
- jtag_tck_o  out  1  to jtag_tck_i.
- jtag_tms_o  out  1  to jtag_tms_i.
- jtag_tdi_o  out  1  to jtag_tdi_i.
- jtag_trst_o  out  1  to jtag_trst_i, active-low.
- jtag_tdo_i  in  1  from jtag_tdo_o.

Behaviour:
- Reset values: cmd_ready_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, tck=0, tms=1, tdi=0, trst=1. All outputs are registered.
- TCK generation:
  - Phase counter runs 0..DIV-1; TCK toggles when it wraps.
  - TCK runs only in non-idle states and rests low.
  - TMS/TDI update on the falling edge, i.e. the same ref cycle TCK goes 1->0. The first bit is presented at least DIV cycles before the first rise.
  - TDO is sampled on the ref cycle TCK goes 0->1.
- FSM states: TLR_SEQ, IDLE, WALK_IN, SHIFT, WALK_OUT, RESP.
  - TLR_SEQ: entered after reset. TMS=1 for 5 TCK, then TMS=0 for 1 TCK (TAP ends in RTI) -> IDLE.
  - IDLE: cmd_ready_o=1. On accept, latch is_ir, len and data -> WALK_IN. If len==0 or len>MAX_LEN -> RESP directly, with rsp_err_o=1, rsp_data_o=0 and no TCK activity.
  - WALK_IN: TMS sequence 1,0,0 for DR (Select-DR, Capture, Shift) or 1,1,0,0 for IR.
  - SHIFT: len TCK cycles. TDI = data[i]. TMS=0 except TMS=1 on the last bit (Exit1). TDO is sampled each rise into rsp_data[i].
  - WALK_OUT: TMS 1 (Update), then 0 (RTI) -> RESP.
  - RESP: rsp_valid_o=1. When rsp_valid&&rsp_ready -> IDLE. cmd_ready_o=0 while a response is pending.
- TCK count per command: DR len+5, IR len+6.
- rsp_valid_o asserts 1 ref cycle after the final TCK falling edge.
- Reset mid-operation (rst_i at any cycle):
  - Aborts immediately and returns outputs to reset values.
  - Any pending response is dropped.
  - TLR_SEQ reruns, so TAP state is always recovered.
- cmd_valid_i while not ready: ignored; inputs need not be stable.

Optional Feature:
- Macro: JTAG_SHIFT_ENGINE_TRST_EN.
- Defined: jtag_trst_o=0 for the first 2 TCK periods of TLR_SEQ. TCK runs during this window, and TMS=1 throughout.
- Undefined: jtag_trst_o is constant 1; TLR_SEQ relies on TMS only.

Decomposition:
- Package jtag_shift_engine_pkg:
  - state enum jtag_eng_state_e;
  - TLR_TMS_ONES=5;
  - DR_WALK_IN and IR_WALK_IN TMS pattern constants with their lengths.
- Sub-module jtag_tck_gen: phase counter, tck register, rise/fall strobes, enable input.

Test Plan:
1. Release rst_i -> exactly 5 TCK with TMS=1 then 1 with TMS=0; cmd_ready_o rises after the last fall; trst_o=1 without the macro.
2. DR cmd, len=32, data=0xDEADBEEF, tdo_i looped to tdi_o through a 1-TCK delay model -> 37 TCK pulses; TMS pattern 1,0,0,0x31,1,1,0; rsp_data_o=0xDEADBEEF<<1 (bit0 = initial model state 0), rsp_err_o=0.
3. IR cmd, len=5, data=0x01, tdo_i=1 constant -> 11 TCK; rsp_data_o=0x1F.
4. len=0 and len=65 -> no TCK edges; rsp_valid with rsp_err_o=1, rsp_data_o=0.
5. Hold rsp_ready_i=0 for 20 cycles -> rsp_valid_o and rsp_data_o stable, cmd_ready_o=0, no TCK; rsp_ready_i=1 -> IDLE next cycle.
6. Assert rst_i mid-SHIFT (bit 10 of 32) -> next cycle outputs at reset values; TLR_SEQ reruns; a following DR len=8 cmd completes correctly. With JTAG_SHIFT_ENGINE_TRST_EN, trst_o is low for 2 TCK.
